// File: rtl/uart_pkg.sv
// Shared types and frame-timing constants for the UART transmit path.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        GAP
    } state_t;

    localparam int BAUD_DIV       = 4167;
    localparam int FRAME_BITS     = 11;
    // Slack on top of one full frame so a slow-but-alive transmitter is never aborted.
    localparam int TIMEOUT_MARGIN = 4163;
    localparam int DEF_TIMEOUT    = FRAME_BITS * BAUD_DIV + TIMEOUT_MARGIN;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Round-robin pick: first asserted request at or after rr_ptr, searching cyclically.
// Purely combinational, zero latency; no backpressure, result is valid whenever any=1.
module rr_arbiter_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        winner   = '0;
        index    = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any   = 1'b1;
                index = cand_idx;
            end
        end
        if (any) begin
            winner[index] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX among N_REQ byte sources, with ack and hung-frame timeout.
// Request sampled in IDLE gives tx_start next cycle; tx_busy holds off any new grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT,
    parameter int GAP_CYC     = 2
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        ack,
    output logic                    timeout_err,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    input  logic                    tx_finish
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    state_t                         state;
    state_t                         state_nxt;
    logic [IDX_W-1:0]               rr_ptr;
    logic [IDX_W-1:0]               owner;
    logic [IDX_W-1:0]               pick_idx;
    logic [N_REQ-1:0]               pick_oh;
    logic                           pick_any;
    logic [TMR_W-1:0]               timer;
    logic [GAP_W-1:0]               gap_cnt;
    logic [N_REQ-1:0][DATA_W-1:0]   req_bytes;
    logic                           launch_go;
    logic                           frame_done;
    logic                           frame_abort;
    logic                           gap_end;

    assign req_bytes = req_data;

    rr_arbiter_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (pick_oh),
        .index  (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch_go) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (frame_done || frame_abort) state_nxt = GAP;
            GAP:     if (gap_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A finish on the last timer cycle still counts as a good frame.
    always_comb begin
        tx_start    = (state == LAUNCH);
        launch_go   = (state == IDLE) && pick_any && !tx_busy;
        frame_done  = (state == WAIT) && tx_finish;
        frame_abort = (state == WAIT) && !tx_finish && (timer == TMR_LAST);
        gap_end     = (state == GAP) && (gap_cnt == GAP_LAST);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            grant       <= '0;
            ack         <= '0;
            timeout_err <= 1'b0;
            tx_data     <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
        end else begin
            ack         <= '0;
            timeout_err <= 1'b0;

            if (launch_go) begin
                grant   <= pick_oh;
                owner   <= pick_idx;
                tx_data <= req_bytes[pick_idx];
            end

            if (state == LAUNCH) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + 1'b1;
            end

            // Pointer moves past the owner whether the frame finished or was aborted.
            if (frame_done || frame_abort) begin
                grant   <= '0;
                gap_cnt <= '0;
                rr_ptr  <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
                if (frame_done) begin
                    ack <= grant;
                end else begin
                    timeout_err <= 1'b1;
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule
